// File: rtl/conv_window_ctrl_pkg.sv
// conv_pkg: shared definitions for the 3x3 window scheduler.
//   state_t    - controller states (IDLE, STREAM, DRAIN)
//   DEF_PIX_W  - default pixel width
//   WIN_N      - pixels per 3x3 window
//   win_idx    - flat window index of (row r, column c), r/c = 0 oldest
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam int DEF_PIX_W = 8;
  localparam int WIN_N     = 9;

  function automatic int win_idx(input int r, input int c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/conv_window_ctrl_if.sv
// Pixel-in / window-out handshake bundle for conv_window_ctrl.
//   in_valid/in_ready/in_pix           - raster pixel stream into the controller
//   win_valid/win_ready/win_data       - 3x3 window stream out of the controller
//   win_row/win_col                    - frame coordinates of the window centre
// Modports: master = pixel source + window sink, slave = controller.
interface conv_window_ctrl_if #(
  parameter int PIX_W = conv_pkg::DEF_PIX_W
);
  logic                          in_valid;
  logic                          in_ready;
  logic [PIX_W-1:0]              in_pix;
  logic                          win_valid;
  logic                          win_ready;
  logic [conv_pkg::WIN_N*PIX_W-1:0] win_data;
  logic [15:0]                   win_row;
  logic [15:0]                   win_col;

  modport master (
    output in_valid, in_pix, win_ready,
    input  in_ready, win_valid, win_data, win_row, win_col
  );

  modport slave (
    input  in_valid, in_pix, win_ready,
    output in_ready, win_valid, win_data, win_row, win_col
  );
endinterface

// File: rtl/conv_window_ctrl_line_buffer.sv
// line_buffer: one image line of pixels, indexed by column.
//   clk   - clock
//   we    - write enable
//   addr  - column address shared by read and write
//   wdata - pixel to store
//   rdata - combinational read of the stored pixel (value before this cycle's write)
// Contents are not reset: every location is written before it is used for
// an emitted window.
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata = mem_q[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end
endmodule

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: turns a raster pixel stream into 3x3 windows, one per
// interior pixel, for the Sobel convolution stage.
//   clk, rst - clock, synchronous active-high reset
//   start    - one-cycle pulse, begins a frame when idle
//   busy     - frame in progress
//   done     - one-cycle pulse after the last window is consumed
//   bus      - pixel input and window output handshakes (slave side)
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  conv_window_ctrl_if.slave  bus
);
  localparam int          AW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [15:0] LAST_COL = 16'(IMG_W - 1);
  localparam logic [15:0] LAST_ROW = 16'(IMG_H - 1);

  state_t             state_q, state_d;
  logic [15:0]        row_q, row_d, col_q, col_d;
  logic [PIX_W-1:0]   win_q [WIN_N];
  logic [PIX_W-1:0]   win_d [WIN_N];
  logic               win_valid_q, win_valid_d;
  logic [15:0]        win_row_q, win_row_d, win_col_q, win_col_d;
  logic               done_q, done_d;

  logic               in_ready;
  logic               accept;
  logic               emit;
  logic [PIX_W-1:0]   lb0_rd, lb1_rd;
  logic [WIN_N*PIX_W-1:0] win_data_w;

  // A pixel may enter only when the output slot is free or being freed now.
  assign in_ready = (state_q == STREAM) && (!win_valid_q || bus.win_ready);
  assign accept   = bus.in_valid && in_ready;
  // Columns 0/1 of the window hold stale data from the previous line, so
  // only pixels with two full rows and two full columns behind them emit.
  assign emit     = accept && (row_q >= 16'd2) && (col_q >= 16'd2);

  // lb0 holds the previous line, lb1 the line before; lb1 is fed from lb0's
  // read so both shift down one row on the same accept.
  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (col_q[AW-1:0]),
    .wdata (bus.in_pix),
    .rdata (lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (col_q[AW-1:0]),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    win_d       = win_q;
    win_valid_d = win_valid_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          row_d   = 16'd0;
          col_d   = 16'd0;
        end
      end
      STREAM: begin
        if (accept) begin
          if (col_q == LAST_COL) begin
            col_d = 16'd0;
            row_d = row_q + 16'd1;
            if (row_q == LAST_ROW) begin
              state_d = DRAIN;
            end
          end else begin
            col_d = col_q + 16'd1;
          end
        end
      end
      DRAIN: begin
        if (!win_valid_q || bus.win_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Shift window one column left; newest column is {lb1, lb0, pixel}.
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[win_idx(r, 0)] = win_q[win_idx(r, 1)];
        win_d[win_idx(r, 1)] = win_q[win_idx(r, 2)];
      end
      win_d[win_idx(0, 2)] = lb1_rd;
      win_d[win_idx(1, 2)] = lb0_rd;
      win_d[win_idx(2, 2)] = bus.in_pix;
    end

    // A new window replaces a consumed one with no bubble; a consumed
    // window with nothing new behind it empties the output slot.
    if (emit) begin
      win_valid_d = 1'b1;
      win_row_d   = row_q - 16'd1;
      win_col_d   = col_q - 16'd1;
    end else if (bus.win_ready) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      done_q      <= 1'b0;
      for (int k = 0; k < WIN_N; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      done_q      <= done_d;
      win_q       <= win_d;
    end
  end

  for (genvar gi = 0; gi < WIN_N; gi++) begin : g_pack
    assign win_data_w[PIX_W*gi +: PIX_W] = win_q[gi];
  end

  assign bus.in_ready  = in_ready;
  assign bus.win_valid = win_valid_q;
  assign bus.win_data  = win_data_w;
  assign bus.win_row   = win_row_q;
  assign bus.win_col   = win_col_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
endmodule
